tube_disp_arbiter: RTL and testbench
====================================

TUBE_DISP_ARBITER -- requirements
Module: tube_disp_arbiter

Interface
REQ-001 The block SHALL have parameter DWELL, default 25000000, giving the minimum number of cycles a granted value stays displayed before another grant; legal range 2 to 2^26-1.
REQ-002 I_sys_clk  input  1  single clock, all logic on its rising edge.
REQ-003 I_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 I_req0  input  1  requester 0 display request.
REQ-005 I_data0  input  16  requester 0 value, four hex digits.
REQ-006 O_ack0  output  1  one-cycle grant pulse to requester 0.
REQ-007 I_req1  input  1  requester 1 display request.
REQ-008 I_data1  input  16  requester 1 value.
REQ-009 O_ack1  output  1  one-cycle grant pulse to requester 1.
REQ-010 O_en  output  1  enable to the digital-tube driver.
REQ-011 O_disp_data  output  16  value driven to the digital-tube driver.
REQ-012 O_owner  output  2  current display owner: 00 none, 01 requester 0, 10 requester 1.
REQ-013 O_busy  output  1  high while the dwell hold is in progress.

Function
REQ-014 The block SHALL implement two states, IDLE and HOLD, with a 26-bit dwell counter and a last-grant flag.
REQ-015 Requester handshake: the requester SHALL hold req high with stable data until it sees ack; the block samples req and data only in IDLE.
REQ-016 Grant in IDLE at edge T when a request is sampled high, all at edge T:
- capture the winner's data into O_disp_data;
- pulse the winner's ack high for exactly one cycle;
- set O_en=1 and O_owner to the winner;
- load the counter with DWELL-1 and enter HOLD.
REQ-017 Arbitration when both requests are high in IDLE SHALL be round-robin: grant the requester not granted last; the last-grant flag updates on every grant.
REQ-018 Single request: grant it regardless of the last-grant flag.
REQ-019 HOLD behaviour:
- counter==0: go to IDLE at the next edge;
- otherwise decrement the counter;
- never assert ack in HOLD.
Result: HOLD lasts exactly DWELL cycles, and back-to-back acks are spaced DWELL+1 cycles.
REQ-020 O_busy SHALL be 1 exactly while the state is HOLD.
REQ-021 After the first grant, O_en, O_disp_data and O_owner SHALL hold their last granted values through IDLE until the next grant.
REQ-022 A request deasserted before its ack SHALL be withdrawn without effect: no ack, no display change.
REQ-023 A re-request with identical data SHALL still be granted and acked normally.
REQ-024 Ack SHALL never be asserted for a requester whose req was low at the sampling edge.
REQ-025 O_ack0 and O_ack1 SHALL never be high in the same cycle.

Reset
REQ-026 While I_rst_n=0, immediately and independent of the clock, the block SHALL drive:
- O_ack0=0, O_ack1=0, O_en=0, O_disp_data=16'h0000, O_owner=00, O_busy=0;
- state IDLE, counter 0, last-grant flag = requester 1 (so requester 0 wins the first tie).
REQ-027 Reset asserted mid-HOLD SHALL abort the hold and discard the current display.
REQ-028 On reset release, a request held high SHALL be granted at the first rising edge where I_rst_n=1.

Verification (DWELL=4)
REQ-029 Reset values: assert I_rst_n=0 asynchronously mid-cycle -> all outputs are 0 before the next edge.
REQ-030 Single grant: I_req0=1, I_data0=16'hEC1D, sampled at edge T -> at T: O_ack0=1 for one cycle, O_disp_data=EC1D, O_en=1, O_owner=01; O_busy=1 for exactly 4 cycles.
REQ-031 Round-robin: req0 (16'h1111) and req1 (16'h2222) held high continuously from reset release -> grant order 0,1,0,1; acks 5 cycles apart; display alternates 1111/2222.
REQ-032 Request during HOLD: req1 raised 2 cycles after a req0 grant at T -> O_ack1 at T+5, not earlier; display stays at req0 data until then.
REQ-033 Withdrawn request and mid-hold reset:
- req1 pulsed high only during HOLD -> no ack1, display unchanged;
- reset asserted during HOLD with req1 held -> outputs 0, then O_ack1 at the first edge after release.

Source files
------------

// File: rtl/tube_disp_arbiter.sv
// Two-requester round-robin arbiter for a four-digit tube display.
// A granted value is held on the display for DWELL cycles before the next grant.
module tube_disp_arbiter #(
    parameter int unsigned DWELL = 25000000
) (
    input  logic        I_sys_clk,
    input  logic        I_rst_n,
    input  logic        I_req0,
    input  logic [15:0] I_data0,
    output logic        O_ack0,
    input  logic        I_req1,
    input  logic [15:0] I_data1,
    output logic        O_ack1,
    output logic        O_en,
    output logic [15:0] O_disp_data,
    output logic [1:0]  O_owner,
    output logic        O_busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [25:0] LP_CNT_LOAD = 26'(DWELL - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [25:0] r_cnt;
    logic [25:0] w_cnt_nxt;
    logic        r_last;
    logic        w_last_nxt;
    logic        r_ack0;
    logic        w_ack0_nxt;
    logic        r_ack1;
    logic        w_ack1_nxt;
    logic        r_en;
    logic        w_en_nxt;
    logic [15:0] r_disp;
    logic [15:0] w_disp_nxt;
    logic [1:0]  r_owner;
    logic [1:0]  w_owner_nxt;
    logic        w_pick0;
    logic        w_pick1;

    // r_last = 1 means requester 1 won most recently, so requester 0 wins a tie.
    assign w_pick0 = I_req0 & (~I_req1 | r_last);
    assign w_pick1 = I_req1 & (~I_req0 | ~r_last);

    // Next-state and next-output decode for the IDLE/HOLD controller.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_ack0_nxt  = 1'b0;
        w_ack1_nxt  = 1'b0;
        w_en_nxt    = r_en;
        w_disp_nxt  = r_disp;
        w_owner_nxt = r_owner;
        case (r_state)
            ST_IDLE: begin
                if (w_pick0) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = LP_CNT_LOAD;
                    w_last_nxt  = 1'b0;
                    w_ack0_nxt  = 1'b1;
                    w_en_nxt    = 1'b1;
                    w_disp_nxt  = I_data0;
                    w_owner_nxt = 2'b01;
                end else if (w_pick1) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = LP_CNT_LOAD;
                    w_last_nxt  = 1'b1;
                    w_ack1_nxt  = 1'b1;
                    w_en_nxt    = 1'b1;
                    w_disp_nxt  = I_data1;
                    w_owner_nxt = 2'b10;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (r_cnt == 26'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 26'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 26'd0;
            end
        endcase
    end

    // State, dwell counter and registered display outputs.
    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 26'd0;
            r_last  <= 1'b1;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_en    <= 1'b0;
            r_disp  <= 16'h0000;
            r_owner <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_ack0  <= w_ack0_nxt;
            r_ack1  <= w_ack1_nxt;
            r_en    <= w_en_nxt;
            r_disp  <= w_disp_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    assign O_ack0      = r_ack0;
    assign O_ack1      = r_ack1;
    assign O_en        = r_en;
    assign O_disp_data = r_disp;
    assign O_owner     = r_owner;
    assign O_busy      = (r_state == ST_HOLD);

endmodule

// File: tb/tb_tube_disp_arbiter.sv
// Bench for tube_disp_arbiter with DWELL=4: a cycle-level model of the grant
// rules checked every cycle, plus directed scenarios with literal expectations.
module tb_tube_disp_arbiter;

    localparam int DWELL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0;
    logic [15:0] data0 = 16'h0000;
    logic        req1 = 1'b0;
    logic [15:0] data1 = 16'h0000;
    logic        ack0;
    logic        ack1;
    logic        en;
    logic [15:0] disp;
    logic [1:0]  owner;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // model of the observable behaviour
    logic        m_ack0 = 1'b0;
    logic        m_ack1 = 1'b0;
    logic        m_en = 1'b0;
    logic [15:0] m_disp = 16'h0000;
    logic [1:0]  m_owner = 2'b00;
    int          m_last = 1;
    int          m_left = 0;

    tube_disp_arbiter #(.DWELL(DWELL)) dut (
        .I_sys_clk  (clk),
        .I_rst_n    (rst_n),
        .I_req0     (req0),
        .I_data0    (data0),
        .O_ack0     (ack0),
        .I_req1     (req1),
        .I_data1    (data1),
        .O_ack1     (ack1),
        .O_en       (en),
        .O_disp_data(disp),
        .O_owner    (owner),
        .O_busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Model update on each rising edge, then compare DUT outputs just after it.
    always @(posedge clk) begin
        int win;
        cyc++;
        if (!rst_n) begin
            m_ack0 = 1'b0; m_ack1 = 1'b0; m_en = 1'b0;
            m_disp = 16'h0000; m_owner = 2'b00; m_last = 1; m_left = 0;
        end else if (m_left == 0 && (req0 || req1)) begin
            if (req0 && req1) win = (m_last == 1) ? 0 : 1;
            else              win = req0 ? 0 : 1;
            m_ack0  = (win == 0);
            m_ack1  = (win == 1);
            m_en    = 1'b1;
            m_disp  = (win == 0) ? data0 : data1;
            m_owner = (win == 0) ? 2'b01 : 2'b10;
            m_last  = win;
            m_left  = DWELL;
        end else begin
            m_ack0 = 1'b0;
            m_ack1 = 1'b0;
            if (m_left > 0) m_left--;
        end
        #1;
        check("ack0",  {31'd0, ack0},  {31'd0, m_ack0});
        check("ack1",  {31'd0, ack1},  {31'd0, m_ack1});
        check("en",    {31'd0, en},    {31'd0, m_en});
        check("disp",  {16'd0, disp},  {16'd0, m_disp});
        check("owner", {30'd0, owner}, {30'd0, m_owner});
        check("busy",  {31'd0, busy},  {31'd0, (m_left > 0)});
        check("ack_excl", {31'd0, (ack0 & ack1)}, 32'd0);
    end

    task automatic wait_ack(input int who, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if ((who == 0 && ack0) || (who == 1 && ack1)) begin
                at = cyc;
                break;
            end
        end
        check("ack_timeout", {31'd0, (at < 0)}, 32'd0);
    endtask

    task automatic idle_gap();
        repeat (DWELL + 2) @(negedge clk);
    endtask

    initial begin
        int t, t1, r, cnt_b, cnt_a;
        // reset with both requesters already asking
        req0 = 1'b1; data0 = 16'h1111;
        req1 = 1'b1; data1 = 16'h2222;
        repeat (3) @(posedge clk);
        #2;
        check("rst_outputs", {ack0, ack1, en, disp, owner, busy}, 32'd0);

        // round robin from reset release
        @(negedge clk); rst_n = 1'b1;
        r = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            int at = -1;
            int who = -1;
            logic [15:0] d = 16'h0000;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk); #2;
                if (ack0 || ack1) begin
                    at = cyc; who = ack0 ? 0 : 1; d = disp;
                    break;
                end
            end
            check("rr_who",  who, k % 2);
            check("rr_at",   at, r + 5 * k);
            check("rr_data", {16'd0, d}, (k % 2 == 0) ? 32'h1111 : 32'h2222);
        end
        @(negedge clk); req0 = 1'b0; req1 = 1'b0;
        idle_gap();

        // single grant and busy length
        req0 = 1'b1; data0 = 16'hEC1D;
        r = cyc + 1;
        wait_ack(0, 3, t);
        check("sg_at", t, r);
        check("sg_disp", {16'd0, disp}, 32'h0000EC1D);
        check("sg_en_owner", {29'd0, en, owner}, 32'h5);
        cnt_b = busy ? 1 : 0;
        cnt_a = 0;
        @(negedge clk); req0 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #2;
            if (busy) cnt_b++;
            if (ack0) cnt_a++;
        end
        check("sg_busy_len", cnt_b, 4);
        check("sg_single_ack", cnt_a, 0);
        idle_gap();

        // request arriving during HOLD
        req0 = 1'b1; data0 = 16'h0A0A;
        wait_ack(0, 3, t);
        @(negedge clk); req0 = 1'b0;
        @(negedge clk); req1 = 1'b1; data1 = 16'hB0B0;
        wait_ack(1, 10, t1);
        check("hold_req_at", t1, t + 5);
        check("hold_req_disp", {16'd0, disp}, 32'h0000B0B0);
        @(negedge clk); req1 = 1'b0;
        idle_gap();

        // withdrawn request
        req0 = 1'b1; data0 = 16'h1234;
        wait_ack(0, 3, t);
        @(negedge clk); req0 = 1'b0;
        @(negedge clk); req1 = 1'b1; data1 = 16'hBEEF;
        @(negedge clk); req1 = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            if (ack1) cnt_a++;
        end
        check("wd_no_ack", cnt_a, 0);
        check("wd_disp", {16'd0, disp}, 32'h00001234);
        idle_gap();

        // reset in the middle of a hold with req1 pending
        req0 = 1'b1; data0 = 16'h5555;
        wait_ack(0, 3, t);
        @(negedge clk); req0 = 1'b0; req1 = 1'b1; data1 = 16'h6666;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", {ack0, ack1, en, disp, owner, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        r = cyc + 1;
        wait_ack(1, 3, t1);
        check("rel_ack_at", t1, r);
        check("rel_disp", {16'd0, disp}, 32'h00006666);
        @(negedge clk); req1 = 1'b0;
        idle_gap();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
